// File: rtl/and14_qual_pkg.sv
// Shared types and constants for the 14-input AND event qualifier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   NUM_IN      number of product-term inputs
//   state_t     qualifier FSM state encoding (2 bits)
//   hcnt_width  width of the hold/release run counter
package and14_qual_pkg;

  localparam int NUM_IN = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMING  = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // The run counter only ever counts up to max(hold, rel) - 1. The extra
  // bit keeps the width at least 1 when both parameters are 1.
  function automatic int hcnt_width(input int hold_cyc, input int rel_cyc);
    int m;
    m = (hold_cyc > rel_cyc) ? hold_cyc : rel_cyc;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/and14_event_qualifier_if.sv
// Signal bundle between the qualifier and whoever drives its product terms.
// Latency: n/a (wires only).
// Backpressure: none; the qualifier accepts a sample on every enabled edge.
//
// Signals:
//   CE   clock enable (0 freezes all qualifier state)
//   CLR  clear of CNT/OVF only
//   A    product-term inputs
//   M    per-input mask, M[i]=0 forces A[i] true
//   Z0   qualified AND level
//   ZR   one-cycle pulse on Z0 rising
//   ZF   one-cycle pulse on Z0 falling
//   CNT  saturating rise-event count
//   OVF  sticky: rise seen while CNT saturated
interface and14_event_qualifier_if #(
  parameter int CNT_W = 8
);
  import and14_qual_pkg::*;

  logic              CE;
  logic              CLR;
  logic [NUM_IN-1:0] A;
  logic [NUM_IN-1:0] M;
  logic              Z0;
  logic              ZR;
  logic              ZF;
  logic [CNT_W-1:0]  CNT;
  logic              OVF;

  // master: the block feeding product terms and consuming the decision
  modport master (
    output CE, CLR, A, M,
    input  Z0, ZR, ZF, CNT, OVF
  );

  // slave: the qualifier itself
  modport slave (
    input  CE, CLR, A, M,
    output Z0, ZR, ZF, CNT, OVF
  );

endinterface

// File: rtl/evt_sat_counter.sv
// Saturating event counter with sticky overflow flag.
// Latency: cnt/ovf update on the edge where inc is sampled high.
// Backpressure: none; ce=0 holds cnt/ovf, including any clr request.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   ce   clock enable
//   inc  count one event this edge
//   clr  clear cnt and ovf (an inc on the same edge still counts: cnt=1)
//   cnt  event count, holds at all-ones
//   ovf  sticky, set by an inc while cnt is already all-ones
module evt_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (ce) begin
      if (clr) begin
        // The clear wins over history but not over the event that
        // arrives with it, so a coincident rise is still counted.
        cnt_q <= inc ? CNT_ONE : '0;
        ovf_q <= 1'b0;
      end else if (inc) begin
        if (cnt_q == CNT_MAX) begin
          ovf_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/and14_event_qualifier.sv
// Glitch-filtered, masked 14-input AND decision with edge pulses and event count.
// Latency: all-true captured at edge k and held -> Z0 rises at edge k+HOLD_CYC;
//          false captured at edge j -> Z0 falls at edge j+REL_CYC.
// Backpressure: none; CE=0 freezes every register and suppresses ZR/ZF.
//
// Ports:
//   CK   clock
//   CD   synchronous active-high reset, overrides CE
//   bus  slave side of and14_event_qualifier_if (CE, CLR, A, M in;
//        Z0, ZR, ZF, CNT, OVF out)
module and14_event_qualifier
  import and14_qual_pkg::*;
#(
  parameter int HOLD_CYC = 3,
  parameter int REL_CYC  = 2,
  parameter int CNT_W    = 8
) (
  input  logic                        CK,
  input  logic                        CD,
  and14_event_qualifier_if.slave      bus
);

  localparam int HW = hcnt_width(HOLD_CYC, REL_CYC);

  localparam logic [HW-1:0] HCNT_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] REL_LAST  = HW'(REL_CYC - 1);

  // ---------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------
  logic [NUM_IN-1:0] areg;
  state_t            state;
  logic [HW-1:0]     hcnt;
  logic              zr_q;
  logic              zf_q;

  // ---------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------
  state_t            state_n;
  logic [HW-1:0]     hcnt_n;
  logic              rise_n;
  logic              fall_n;
  logic              raw;

  // Masked-off inputs read as true, so an all-zero mask is a vacuous match.
  // The mask is applied live, not captured, so a mask change is seen on
  // the very next evaluation.
  assign raw = &(areg | ~bus.M);

  // ---------------------------------------------------------------------
  // Qualifier FSM: next state
  // hcnt counts consecutive agreeing samples in ARMING / RELEASE and is
  // kept at zero in the steady states.
  // ---------------------------------------------------------------------
  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    rise_n  = 1'b0;
    fall_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (raw) begin
          if (HOLD_CYC == 1) begin
            state_n = ACTIVE;
            hcnt_n  = '0;
            rise_n  = 1'b1;
          end else begin
            state_n = ARMING;
            hcnt_n  = HCNT_ONE;
          end
        end
      end

      ARMING: begin
        if (!raw) begin
          state_n = IDLE;
          hcnt_n  = '0;
        end else if (hcnt == HOLD_LAST) begin
          state_n = ACTIVE;
          hcnt_n  = '0;
          rise_n  = 1'b1;
        end else begin
          hcnt_n  = hcnt + HCNT_ONE;
        end
      end

      ACTIVE: begin
        if (!raw) begin
          if (REL_CYC == 1) begin
            state_n = IDLE;
            hcnt_n  = '0;
            fall_n  = 1'b1;
          end else begin
            state_n = RELEASE;
            hcnt_n  = HCNT_ONE;
          end
        end
      end

      RELEASE: begin
        // Bouncing back to ACTIVE keeps Z0 high throughout: not a rise.
        if (raw) begin
          state_n = ACTIVE;
          hcnt_n  = '0;
        end else if (hcnt == REL_LAST) begin
          state_n = IDLE;
          hcnt_n  = '0;
          fall_n  = 1'b1;
        end else begin
          hcnt_n  = hcnt + HCNT_ONE;
        end
      end

      default: begin
        state_n = IDLE;
        hcnt_n  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Capture register, state register and edge pulses
  // ---------------------------------------------------------------------
  always_ff @(posedge CK) begin
    if (CD) begin
      areg  <= '0;
      state <= IDLE;
      hcnt  <= '0;
      zr_q  <= 1'b0;
      zf_q  <= 1'b0;
    end else if (bus.CE) begin
      areg  <= bus.A;
      state <= state_n;
      hcnt  <= hcnt_n;
      zr_q  <= rise_n;
      zf_q  <= fall_n;
    end else begin
      // Frozen edge: state holds but pulses must not be stretched.
      zr_q  <= 1'b0;
      zf_q  <= 1'b0;
    end
  end

  // Z0 decodes directly from the state register, so it is a registered level.
  assign bus.Z0 = (state == ACTIVE) || (state == RELEASE);
  assign bus.ZR = zr_q;
  assign bus.ZF = zf_q;

  // ---------------------------------------------------------------------
  // Rise-event counter. It sees the same CE as the FSM, so a rise is
  // counted on exactly the edge that enters ACTIVE.
  // ---------------------------------------------------------------------
  evt_sat_counter #(
    .CNT_W (CNT_W)
  ) u_evt_cnt (
    .clk (CK),
    .rst (CD),
    .ce  (bus.CE),
    .inc (rise_n),
    .clr (bus.CLR),
    .cnt (bus.CNT),
    .ovf (bus.OVF)
  );

endmodule

// File: tb/tb_and14_event_qualifier.sv
// Self-checking bench for and14_event_qualifier (HOLD=3, REL=2, CNT_W=2).
// A run-length reference model predicts each cycle's outputs into a queue
// when stimulus is driven; the entry is popped and compared after the edge.
module tb_and14_event_qualifier;

  localparam int HOLD = 3;
  localparam int REL  = 2;
  localparam int CW   = 2;
  localparam logic [13:0] ALL = 14'h3FFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  and14_event_qualifier_if #(.CNT_W(CW)) bus ();

  and14_event_qualifier #(
    .HOLD_CYC (HOLD),
    .REL_CYC  (REL),
    .CNT_W    (CW)
  ) dut (
    .CK  (clk),
    .CD  (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic          z0;
    logic          zr;
    logic          zf;
    logic [CW-1:0] cnt;
    logic          ovf;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: counts consecutive raw samples of the opposite
  // polarity to the current level, flipping the level when the run hits
  // the hold/release length.
  logic [13:0] m_areg = '0;
  logic        m_z0   = 1'b0;
  logic        m_zr   = 1'b0;
  logic        m_zf   = 1'b0;
  logic        m_ovf  = 1'b0;
  int          m_tr   = 0;
  int          m_fr   = 0;
  int          m_cnt  = 0;

  task automatic cyc(input logic r, input logic ce, input logic clr,
                     input logic [13:0] a, input logic [13:0] m);
    logic raw;
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst     = r;
    bus.CE  = ce;
    bus.CLR = clr;
    bus.A   = a;
    bus.M   = m;

    if (r) begin
      m_areg = '0; m_z0 = 0; m_zr = 0; m_zf = 0; m_ovf = 0;
      m_tr = 0; m_fr = 0; m_cnt = 0;
    end else if (ce) begin
      raw    = &(m_areg | ~m);
      m_areg = a;
      m_zr   = 0;
      m_zf   = 0;
      if (!m_z0) begin
        m_tr = raw ? m_tr + 1 : 0;
        if (m_tr == HOLD) begin m_z0 = 1; m_zr = 1; m_tr = 0; end
      end else begin
        m_fr = raw ? 0 : m_fr + 1;
        if (m_fr == REL) begin m_z0 = 0; m_zf = 1; m_fr = 0; end
      end
      if (clr) begin
        m_cnt = m_zr ? 1 : 0;
        m_ovf = 0;
      end else if (m_zr) begin
        if (m_cnt == (1 << CW) - 1) m_ovf = 1;
        else m_cnt++;
      end
    end else begin
      m_zr = 0;
      m_zf = 0;
    end

    e.z0 = m_z0; e.zr = m_zr; e.zf = m_zf; e.cnt = CW'(m_cnt); e.ovf = m_ovf;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("z0",  bus.Z0,  got.z0);
    check("zr",  bus.ZR,  got.zr);
    check("zf",  bus.ZF,  got.zf);
    check("cnt", bus.CNT, got.cnt);
    check("ovf", bus.OVF, got.ovf);
  endtask

  task automatic run(input int n, input logic [13:0] a, input logic [13:0] m);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, a, m);
  endtask

  int zfc;
  int zrc;

  initial begin
    bus.CE = 1'b1; bus.CLR = 1'b0; bus.A = ALL; bus.M = ALL;

    // 1: reset with inputs all-true, then exact rise latency
    cyc(1'b1, 1'b1, 1'b0, ALL, ALL);
    cyc(1'b1, 1'b0, 1'b0, ALL, ALL);
    check("t1_rst_z0",  bus.Z0,  0);
    check("t1_rst_cnt", bus.CNT, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, ALL, ALL);
      check("t1_lat_z0", bus.Z0, (i == 4) ? 1 : 0);
    end
    check("t1_zr", bus.ZR, 1);
    run(2, ALL, ALL);
    run(4, 14'h0000, ALL);
    check("t1_fell", bus.Z0, 0);

    // 2: short all-true run then one input drops: never qualifies
    cyc(1'b0, 1'b1, 1'b1, 14'h0000, ALL);
    zrc = 0;
    run(2, ALL, ALL);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0, ALL & ~14'h0080, ALL);
      zrc += int'(bus.ZR) + int'(bus.Z0);
    end
    check("t2_no_rise", zrc, 0);
    check("t2_cnt", bus.CNT, 0);

    // 3: single-cycle glitch filtered, two-cycle drop releases
    run(5, ALL, ALL);
    check("t3_active", bus.Z0, 1);
    zfc = 0;
    cyc(1'b0, 1'b1, 1'b0, ALL & ~14'h0001, ALL);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, ALL, ALL);
      zfc += int'(bus.ZF) + int'(!bus.Z0);
    end
    check("t3_glitch", zfc, 0);
    zfc = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 1'b0, ALL & ~14'h0001, ALL);
      zfc += int'(bus.ZF);
    end
    check("t3_zf_once", zfc, 1);
    check("t3_z0_low", bus.Z0, 0);

    // 4: single unmasked input; masked inputs toggle freely
    for (int i = 0; i < 5; i++)
      cyc(1'b0, 1'b1, 1'b0, {13'($urandom), 1'b1}, 14'h0001);
    check("t4_assert", bus.Z0, 1);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 1'b1, 1'b0, {13'($urandom), 1'b0}, 14'h0001);
    check("t4_release", bus.Z0, 0);

    // 5: saturation and coincident clear
    cyc(1'b0, 1'b1, 1'b1, 14'h0000, ALL);
    for (int r = 0; r < 5; r++) begin
      run(4, ALL, ALL);
      run(3, 14'h0000, ALL);
    end
    check("t5_cnt_sat", bus.CNT, 3);
    check("t5_ovf",     bus.OVF, 1);
    run(3, ALL, ALL);
    cyc(1'b0, 1'b1, 1'b1, ALL, ALL);
    check("t5_clr_rise_z0",  bus.Z0,  1);
    check("t5_clr_rise_cnt", bus.CNT, 1);
    check("t5_clr_rise_ovf", bus.OVF, 0);
    run(3, 14'h0000, ALL);

    // 6: freeze mid-ARMING, resume and finish the hold
    run(2, ALL, ALL);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b0, 14'h0000, ALL);
      check("t6_frozen", bus.Z0, 0);
    end
    cyc(1'b0, 1'b1, 1'b0, ALL, ALL);
    check("t6_resume1", bus.Z0, 0);
    cyc(1'b0, 1'b1, 1'b0, ALL, ALL);
    check("t6_resume2", bus.Z0, 1);

    // Mixed random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [13:0] a;
      logic [13:0] m;
      a = ($urandom_range(0, 5) == 0) ? 14'($urandom) : ALL;
      m = ($urandom_range(0, 7) == 0) ? 14'($urandom) : ALL;
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 15) == 0), a, m);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
